// File: rtl/joy_pkg.sv
// joy_pkg: shared scan state type and size limits for the serial joystick reader
package joy_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} scan_state_t;
  localparam int MAX_PLAYERS = 4;
  localparam int MAX_BITS = 16;
endpackage

// File: rtl/joy_tick_gen.sv
// joy_tick_gen: free-running divider producing a 1-clk tick every CLK_DIV clks
module joy_tick_gen #(
  parameter int CLK_DIV = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  // divider count, restarted by reset or clear
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/joy_serial_scan.sv
// joy_serial_scan: scans chained active-low joystick shift registers into debounced active-high words
module joy_serial_scan
  import joy_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV = 48,
  parameter int IDLE_TICKS = 16,
  parameter int DEBOUNCE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic joy_data,
  output logic joy_clk,
  output logic joy_load,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic frame_done,
  output logic frame_err
);
  localparam int TOTAL = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int IW = IDLE_TICKS > 1 ? $clog2(IDLE_TICKS) : 1;
  localparam int BW = TOTAL > 1 ? $clog2(TOTAL) : 1;
  scan_state_t state, next_state;
  logic tick, clear, last_idle, last_bit, primed;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] bit_idx;
  logic [TOTAL-1:0] shift, prev;
  // the divider restarts after DONE so every frame has the same length
  assign clear = !enable || state == DONE;
  assign last_idle = idle_cnt == IW'(IDLE_TICKS - 1);
  assign last_bit = bit_idx == BW'(TOTAL - 1);
  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .tick(tick)
  );
  // state register, forced to IDLE on reset or disable
  always_ff @(posedge clk)
    state <= (reset || !enable) ? IDLE : next_state;
  // next-state: advance on tick, DONE lasts one clk
  always_comb
    next_state = state == DONE ? IDLE :
                 !tick ? state :
                 state == IDLE ? (last_idle ? LOAD : IDLE) :
                 state == LOAD ? LOW :
                 state == LOW ? HIGH :
                 last_bit ? DONE : LOW;
  // adapter strobes decoded from state
  always_comb begin
    joy_load = state != LOAD;
    joy_clk = state != LOW;
  end
  // idle and bit counters
  always_ff @(posedge clk)
    if (reset || !enable) begin
      idle_cnt <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      idle_cnt <= state == IDLE && !last_idle ? idle_cnt + 1'b1 : '0;
      bit_idx <= state == LOAD ? '0 : state == HIGH && !last_bit ? bit_idx + 1'b1 : bit_idx;
    end
  // capture the inverted data bit on the tick that raises joy_clk
  always_ff @(posedge clk)
    if (tick && state == LOW) shift[bit_idx] <= ~joy_data;
  // frame evaluation; the first frame after reset/enable only primes prev
  always_ff @(posedge clk)
    if (reset || !enable) begin
      joystick <= '0;
      prev <= '0;
      primed <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_done <= state == DONE;
      frame_err <= state == DONE && DEBOUNCE != 0 && primed && shift != prev;
      if (state == DONE) begin
        prev <= shift;
        primed <= 1'b1;
        if (DEBOUNCE == 0 || (primed && shift == prev)) joystick <= shift;
      end
    end
endmodule

// File: tb/tb_joy_serial_scan.sv
// tb_joy_serial_scan: directed checks of the serial joystick scanner in three configurations
module tb_joy_serial_scan;
  logic clk = 0, reset = 1, enable = 1;
  logic [23:0] pat_a = 24'h000FFF, pat_b = 24'h0;
  logic [63:0] pat_c = 64'h8000_0000_0000_0000;
  logic data_a, data_b, data_c;
  logic jclk_a, jclk_b, jclk_c, jload_a, jload_b, jload_c;
  logic fd_a, fd_b, fd_c, fe_a, fe_b, fe_c;
  logic [23:0] joy_a, joy_b;
  logic [63:0] joy_c;
  int idx_a = 0, idx_b = 0, idx_c = 0;
  int tests = 0, fails = 0;
  int n, ll, pulses, r;
  logic prevc;

  always #5 clk = ~clk;

  joy_serial_scan #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .CLK_DIV(4), .IDLE_TICKS(2), .DEBOUNCE(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(data_a), .joy_clk(jclk_a),
    .joy_load(jload_a), .joystick(joy_a), .frame_done(fd_a), .frame_err(fe_a));
  joy_serial_scan #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .CLK_DIV(4), .IDLE_TICKS(2), .DEBOUNCE(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(data_b), .joy_clk(jclk_b),
    .joy_load(jload_b), .joystick(joy_b), .frame_done(fd_b), .frame_err(fe_b));
  joy_serial_scan #(.NUM_PLAYERS(4), .BITS_PER_PLAYER(16), .CLK_DIV(4), .IDLE_TICKS(2), .DEBOUNCE(1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(data_c), .joy_clk(jclk_c),
    .joy_load(jload_c), .joystick(joy_c), .frame_done(fd_c), .frame_err(fe_c));

  // adapter models: load resets the bit pointer, each rising shift clock advances it
  always @(negedge jload_a) idx_a <= 0;
  always @(posedge jclk_a) idx_a <= idx_a + 1;
  always @(negedge jload_b) idx_b <= 0;
  always @(posedge jclk_b) idx_b <= idx_b + 1;
  always @(negedge jload_c) idx_c <= 0;
  always @(posedge jclk_c) idx_c <= idx_c + 1;
  assign data_a = idx_a < 24 ? ~pat_a[idx_a] : 1'b1;
  assign data_b = idx_b < 24 ? ~pat_b[idx_b] : 1'b1;
  assign data_c = idx_c < 64 ? ~pat_c[idx_c] : 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input int d, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(d == 0 ? fd_a : d == 1 ? fd_b : fd_c) && cnt < 3000);
    if (cnt >= 3000) check("frame_timeout", 64'(cnt), 64'd0);
  endtask

  task automatic wait_load(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (jload_a && cnt < 3000);
    if (cnt >= 3000) check("load_timeout", 64'(cnt), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_clk", jclk_a, 1);
    check("rst_load", jload_a, 1);
    check("rst_joy", joy_a, 0);
    check("rst_done", fd_a, 0);
    check("rst_err", fe_a, 0);
    reset = 0;
    // first frame: load width, shift pulse count, length, primed-only result
    n = 0; ll = 0; pulses = 0; prevc = 1;
    while (!fd_a && n < 3000) begin
      @(negedge clk);
      n++;
      ll += int'(!jload_a);
      if (prevc && !jclk_a) pulses++;
      prevc = jclk_a;
    end
    check("f1_len", 64'(n), 205);
    check("f1_load_clks", 64'(ll), 4);
    check("f1_pulses", 64'(pulses), 24);
    check("f1_joy", joy_a, 0);
    check("f1_err", fe_a, 0);
    wait_frame(0, n);
    check("f2_len", 64'(n), 205);
    check("f2_joy", joy_a, 24'h000FFF);
    check("f2_err", fe_a, 0);
    // debounce across pattern changes
    pat_a = 24'h000001;
    wait_frame(0, n);
    check("chg1_err", fe_a, 1);
    check("chg1_joy", joy_a, 24'h000FFF);
    wait_frame(0, n);
    check("acc1_err", fe_a, 0);
    check("acc1_joy", joy_a, 24'h000001);
    pat_a = 24'h000002;
    wait_frame(0, n);
    check("chg2_err", fe_a, 1);
    check("chg2_joy", joy_a, 24'h000001);
    wait_frame(0, n);
    check("acc2_err", fe_a, 0);
    check("acc2_joy", joy_a, 24'h000002);
    // no-debounce instance: absent adapter reads zero, updates every frame
    wait_frame(1, n);
    check("nd_joy0", joy_b, 0);
    wait_frame(1, n);
    check("nd_period", 64'(n), 205);
    check("nd_joy1", joy_b, 0);
    check("nd_err", fe_b, 0);
    pat_b = 24'h123456;
    wait_frame(1, n);
    check("nd_joy_pat", joy_b, 24'h123456);
    check("nd_err_pat", fe_b, 0);
    pat_b = 24'h0;
    wait_frame(1, n);
    check("nd_joy_clr", joy_b, 0);
    // 4x16 instance: top bit only
    wait_frame(2, n);
    check("w64_joy", joy_c, 64'h8000_0000_0000_0000);
    check("w64_err", fe_c, 0);
    wait_frame(2, n);
    check("w64_period", 64'(n), 525);
    check("w64_joy2", joy_c, 64'h8000_0000_0000_0000);
    // abort at bit 10 via enable
    wait_load(n);
    r = 0; n = 0; prevc = jclk_a;
    while ((r < 10 || jclk_a) && n < 3000) begin
      @(negedge clk);
      n++;
      if (!prevc && jclk_a) r++;
      prevc = jclk_a;
    end
    check("abort_rises", 64'(r), 10);
    enable = 0;
    @(negedge clk);
    check("dis_clk", jclk_a, 1);
    check("dis_load", jload_a, 1);
    check("dis_joy", joy_a, 0);
    n = 0;
    repeat (300) begin
      @(negedge clk);
      n += int'(fd_a);
    end
    check("dis_no_done", 64'(n), 0);
    enable = 1;
    wait_load(n);
    check("reen_load_delay", 64'(n), 8);
    wait_frame(0, n);
    check("reen_f1_joy", joy_a, 0);
    check("reen_f1_err", fe_a, 0);
    wait_frame(0, n);
    check("reen_f2_joy", joy_a, 24'h000002);
    // reset during HIGH
    n = 0;
    while (jclk_a && n < 3000) begin @(negedge clk); n++; end
    while (!jclk_a && n < 3000) begin @(negedge clk); n++; end
    reset = 1;
    @(negedge clk);
    check("mid_rst_clk", jclk_a, 1);
    check("mid_rst_load", jload_a, 1);
    check("mid_rst_joy", joy_a, 0);
    check("mid_rst_done", fd_a, 0);
    check("mid_rst_err", fe_a, 0);
    @(negedge clk);
    reset = 0;
    wait_load(n);
    check("rst_restart_delay", 64'(n), 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
